// File: rtl/port_a_handshake_ctrl.sv
// Port A control/handshake sequencer for an 8255-style PPI: decodes control words and BSR
// commands, drives the Port A buffer enables and runs the Mode 0 / Mode 1 strobed handshakes.
module port_a_handshake_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] a,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  input  logic       stb_n,
  input  logic       ack_n,
  output logic       pa_en,
  output logic       pa_dir,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr,
  output logic [1:0] mode_a
);

  typedef enum logic [2:0] {
    StUncfg,
    StM0In,
    StM0Out,
    StM1InEmpty,
    StM1InFull,
    StM1OutEmpty,
    StM1OutFull
  } state_e;

  state_e      state;
  logic        rd_q, wr_q;
  logic [2:0]  stb_sync, ack_sync;
  logic        inte_in, inte_out;
  logic [7:0]  in_latch;

  logic        rd_start, rd_end, wr_start, wr_end;
  logic        stb_fall, stb_rise, ack_fall, ack_rise;
  logic        m1_in, m1_out, pa_sel, ctl_sel;
  logic [7:0]  rd_data;

  assign rd_start = ~cs_n & rd_q & ~rd_n;
  assign rd_end   = ~cs_n & ~rd_q & rd_n;
  assign wr_start = ~cs_n & wr_q & ~wr_n;
  assign wr_end   = ~cs_n & ~wr_q & wr_n;

  // [0],[1] are the synchronizer flops, [2] holds the previous synchronized level.
  assign stb_fall = stb_sync[2] & ~stb_sync[1];
  assign stb_rise = ~stb_sync[2] & stb_sync[1];
  assign ack_fall = ack_sync[2] & ~ack_sync[1];
  assign ack_rise = ~ack_sync[2] & ack_sync[1];

  assign m1_in   = (state == StM1InEmpty) || (state == StM1InFull);
  assign m1_out  = (state == StM1OutEmpty) || (state == StM1OutFull);
  assign pa_sel  = (a == 2'b00);
  assign ctl_sel = (a == 2'b11);

  always_comb begin
    rd_data = 8'h00;
    case (a)
      2'b00: begin
        if (state == StUncfg) rd_data = 8'h00;
        else if (m1_in)       rd_data = in_latch;
        else if (m1_out)      rd_data = pa_out;
        else                  rd_data = pa_in;
      end
      2'b10:   rd_data = {obf_n, inte_out, ibf, inte_in, intr, 3'b000};
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StUncfg;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      stb_sync <= 3'b111;
      ack_sync <= 3'b111;
      inte_in  <= 1'b0;
      inte_out <= 1'b0;
      in_latch <= 8'h00;
      d_out    <= 8'h00;
      d_oe     <= 1'b0;
      pa_out   <= 8'h00;
      pa_en    <= 1'b0;
      pa_dir   <= 1'b1;
      ibf      <= 1'b0;
      obf_n    <= 1'b1;
      intr     <= 1'b0;
      mode_a   <= 2'b00;
    end else begin
      rd_q     <= rd_n;
      wr_q     <= wr_n;
      stb_sync <= {stb_sync[1:0], stb_n};
      ack_sync <= {ack_sync[1:0], ack_n};

      // Peripheral events first; CPU actions below override them in the same cycle.
      if (m1_in) begin
        if (stb_fall) begin
          in_latch <= pa_in;
          ibf      <= 1'b1;
          state    <= StM1InFull;
        end
        if (stb_rise && ibf && inte_in) intr <= 1'b1;
      end
      if (m1_out) begin
        if (ack_fall) begin
          obf_n <= 1'b1;
          state <= StM1OutEmpty;
        end
        if (ack_rise && obf_n && inte_out) intr <= 1'b1;
      end

      if (rd_start) begin
        d_out <= rd_data;
        d_oe  <= 1'b1;
        if (pa_sel && m1_in) intr <= 1'b0;
      end
      // Bus release is not gated by chip select so d_oe can never stick high.
      if (rd_n && !rd_q) d_oe <= 1'b0;
      if (rd_end && pa_sel && m1_in) begin
        ibf   <= 1'b0;
        state <= StM1InEmpty;
      end

      if (wr_start) begin
        if (ctl_sel) begin
          if (d_in[7]) begin
            mode_a   <= d_in[6:5];
            pa_dir   <= d_in[4];
            pa_en    <= 1'b1;
            pa_out   <= 8'h00;
            ibf      <= 1'b0;
            obf_n    <= 1'b1;
            intr     <= 1'b0;
            inte_in  <= 1'b0;
            inte_out <= 1'b0;
            if (d_in[6:5] == 2'b01) state <= d_in[4] ? StM1InEmpty : StM1OutEmpty;
            else                    state <= d_in[4] ? StM0In : StM0Out;
          end else begin
            if (d_in[3:1] == 3'd4) begin
              inte_in <= d_in[0];
              if (!d_in[0] && m1_in) intr <= 1'b0;
            end
            if (d_in[3:1] == 3'd6) begin
              inte_out <= d_in[0];
              if (!d_in[0] && m1_out) intr <= 1'b0;
            end
          end
        end else if (pa_sel) begin
          if ((state == StM0In) || (state == StM0Out)) begin
            pa_out <= d_in;
          end else if (m1_out) begin
            pa_out <= d_in;
            intr   <= 1'b0;
          end
        end
      end

      if (wr_end && pa_sel && m1_out) begin
        obf_n <= 1'b0;
        state <= StM1OutFull;
      end
    end
  end

endmodule
